// File: rtl/ir_multibank_buffer.sv
// Double-buffered, multi-channel impulse-response store for the convolution engine.
// The loader fills the shadow page one sample per cycle. The convolver reads LANES
// consecutive taps per cycle from the active page. Pages swap only on an audio_trigger
// after a completed load, so a new IR never tears a frame in progress.
//
// Ports:
//   audio_clk, rst_in         clock, asynchronous active-low reset
//   audio_trigger             one-cycle frame-boundary pulse
//   load_start                begin loading a new IR set into the shadow page
//   wr_valid/wr_ready         write handshake (wr_ready high only while loading)
//   wr_ch/wr_index/wr_data    write channel, tap index, signed tap value
//   wr_last                   final sample of the load
//   wr_err                    one-cycle pulse after an accepted out-of-range write
//   rd_valid/rd_ch/rd_block   read request: taps rd_block*LANES .. +LANES-1
//   rd_data/rd_data_valid     registered read result, latency 1
//   ir_ready                  active page holds a complete IR
//   active_page               page currently read by the convolver
module ir_multibank_buffer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 6000,
  parameter int unsigned LANES      = 8,
  parameter int unsigned NUM_CH     = 2,
  localparam int unsigned ADDR_W    = $clog2(DEPTH),
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned BLK_W     = $clog2(DEPTH / LANES)
) (
  input  logic                                    audio_clk,
  input  logic                                    rst_in,
  input  logic                                    audio_trigger,
  input  logic                                    load_start,
  input  logic                                    wr_valid,
  output logic                                    wr_ready,
  input  logic [CH_W-1:0]                         wr_ch,
  input  logic [ADDR_W-1:0]                       wr_index,
  input  logic signed [DATA_WIDTH-1:0]            wr_data,
  input  logic                                    wr_last,
  output logic                                    wr_err,
  input  logic                                    rd_valid,
  input  logic [CH_W-1:0]                         rd_ch,
  input  logic [BLK_W-1:0]                        rd_block,
  output logic signed [LANES-1:0][DATA_WIDTH-1:0] rd_data,
  output logic                                    rd_data_valid,
  output logic                                    ir_ready,
  output logic                                    active_page
);

  localparam int unsigned BLOCKS = DEPTH / LANES;
  // LANES is a power of two (>= 2), so the low index bits select the bank.
  localparam int unsigned LANE_W = $clog2(LANES);

  typedef enum logic [1:0] {StIdle, StLoading, StPending} state_e;

  state_e state_q, state_d;
  logic   active_page_q;
  logic   ir_ready_q;
  logic   wr_err_q;
  logic   swap;

  logic   wr_fire, wr_en;
  logic   wr_ch_ok, wr_idx_ok, rd_ch_ok, rd_blk_ok;

  logic [LANE_W-1:0] wr_bank;
  logic [BLK_W-1:0]  wr_addr;

  logic [DATA_WIDTH-1:0] mem [2][NUM_CH][LANES][BLOCKS];

  // Range checks collapse to constants when the field width exactly covers the range.
  if (NUM_CH == 2 ** CH_W) begin : g_ch_full
    assign wr_ch_ok = 1'b1;
    assign rd_ch_ok = 1'b1;
  end else begin : g_ch_part
    assign wr_ch_ok = (32'(wr_ch) < NUM_CH);
    assign rd_ch_ok = (32'(rd_ch) < NUM_CH);
  end

  if (DEPTH == 2 ** ADDR_W) begin : g_idx_full
    assign wr_idx_ok = 1'b1;
  end else begin : g_idx_part
    assign wr_idx_ok = (32'(wr_index) < DEPTH);
  end

  if (BLOCKS == 2 ** BLK_W) begin : g_blk_full
    assign rd_blk_ok = 1'b1;
  end else begin : g_blk_part
    assign rd_blk_ok = (32'(rd_block) < BLOCKS);
  end

  assign wr_bank = wr_index[LANE_W-1:0];
  assign wr_addr = wr_index[ADDR_W-1:LANE_W];
  assign wr_fire = wr_valid & wr_ready;
  assign wr_en   = wr_fire & wr_ch_ok & wr_idx_ok;

  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    swap     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_start) state_d = StLoading;
      end
      StLoading: begin
        wr_ready = 1'b1;
        if (wr_fire && wr_last) state_d = StPending;
      end
      StPending: begin
        // Registered entry means a trigger coincident with the wr_last accept is not seen here.
        if (audio_trigger) begin
          swap    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= StIdle;
      active_page_q <= 1'b0;
      ir_ready_q    <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_err_q <= wr_fire & ~(wr_ch_ok & wr_idx_ok);
      if (swap) begin
        active_page_q <= ~active_page_q;
        ir_ready_q    <= 1'b1;
      end
    end
  end

  // Storage is not reset; only the shadow page is ever written.
  always_ff @(posedge audio_clk) begin
    if (wr_en) mem[~active_page_q][wr_ch][wr_bank][wr_addr] <= wr_data;
  end

  // Page select is sampled at issue, so a read in the swap cycle still sees the old page.
  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_valid;
      if (rd_valid) begin
        for (int k = 0; k < LANES; k++) begin
          rd_data[k] <= (rd_ch_ok && rd_blk_ok) ? mem[active_page_q][rd_ch][k][rd_block] : '0;
        end
      end
    end
  end

  assign wr_err      = wr_err_q;
  assign ir_ready    = ir_ready_q;
  assign active_page = active_page_q;

endmodule

// File: tb/tb_ir_multibank_buffer.sv
module tb_ir_multibank_buffer;

  logic audio_clk = 1'b0;
  logic rst_in;
  logic audio_trigger;

  always #5 audio_clk = ~audio_clk;

  // Instance A: default parameters (16b, 6000 taps, 8 lanes, 2 channels)
  logic              a_load_start, a_wr_valid, a_wr_ready, a_wr_last, a_wr_err;
  logic [0:0]        a_wr_ch, a_rd_ch;
  logic [12:0]       a_wr_index;
  logic [15:0]       a_wr_data;
  logic              a_rd_valid, a_rd_data_valid, a_ir_ready, a_active_page;
  logic [9:0]        a_rd_block;
  logic signed [7:0][15:0] a_rd_data;

  // Instance B: LANES=4, NUM_CH=4, DEPTH=64
  logic              b_load_start, b_wr_valid, b_wr_ready, b_wr_last, b_wr_err;
  logic [1:0]        b_wr_ch, b_rd_ch;
  logic [5:0]        b_wr_index;
  logic [15:0]       b_wr_data;
  logic              b_rd_valid, b_rd_data_valid, b_ir_ready, b_active_page;
  logic [3:0]        b_rd_block;
  logic signed [3:0][15:0] b_rd_data;

  // Instance C: LANES=4, NUM_CH=3, DEPTH=16 (exposes an out-of-range channel code)
  logic              c_load_start, c_wr_valid, c_wr_ready, c_wr_last, c_wr_err;
  logic [1:0]        c_wr_ch, c_rd_ch;
  logic [3:0]        c_wr_index;
  logic [15:0]       c_wr_data;
  logic              c_rd_valid, c_rd_data_valid, c_ir_ready, c_active_page;
  logic [1:0]        c_rd_block;
  logic signed [3:0][15:0] c_rd_data;

  ir_multibank_buffer dut_a (
    .audio_clk(audio_clk), .rst_in(rst_in), .audio_trigger(audio_trigger),
    .load_start(a_load_start), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready),
    .wr_ch(a_wr_ch), .wr_index(a_wr_index), .wr_data(a_wr_data), .wr_last(a_wr_last),
    .wr_err(a_wr_err), .rd_valid(a_rd_valid), .rd_ch(a_rd_ch), .rd_block(a_rd_block),
    .rd_data(a_rd_data), .rd_data_valid(a_rd_data_valid), .ir_ready(a_ir_ready),
    .active_page(a_active_page)
  );

  ir_multibank_buffer #(.DATA_WIDTH(16), .DEPTH(64), .LANES(4), .NUM_CH(4)) dut_b (
    .audio_clk(audio_clk), .rst_in(rst_in), .audio_trigger(audio_trigger),
    .load_start(b_load_start), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .wr_ch(b_wr_ch), .wr_index(b_wr_index), .wr_data(b_wr_data), .wr_last(b_wr_last),
    .wr_err(b_wr_err), .rd_valid(b_rd_valid), .rd_ch(b_rd_ch), .rd_block(b_rd_block),
    .rd_data(b_rd_data), .rd_data_valid(b_rd_data_valid), .ir_ready(b_ir_ready),
    .active_page(b_active_page)
  );

  ir_multibank_buffer #(.DATA_WIDTH(16), .DEPTH(16), .LANES(4), .NUM_CH(3)) dut_c (
    .audio_clk(audio_clk), .rst_in(rst_in), .audio_trigger(audio_trigger),
    .load_start(c_load_start), .wr_valid(c_wr_valid), .wr_ready(c_wr_ready),
    .wr_ch(c_wr_ch), .wr_index(c_wr_index), .wr_data(c_wr_data), .wr_last(c_wr_last),
    .wr_err(c_wr_err), .rd_valid(c_rd_valid), .rd_ch(c_rd_ch), .rd_block(c_rd_block),
    .rd_data(c_rd_data), .rd_data_valid(c_rd_data_valid), .ir_ready(c_ir_ready),
    .active_page(c_active_page)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         v;
    logic [9:0]   blk;
    logic         ev;
    logic [127:0] ed;
  } vec_t;

  vec_t tv[8];

  task automatic tick();
    @(posedge audio_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected 8-lane block of instance A when tap i holds mult*i+offs
  function automatic logic [127:0] a_blk(input int b, input int mult, input int offs);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = 16'(mult * (b * 8 + k) + offs);
    return r;
  endfunction

  // Expected 4-lane block when tap i of channel ch holds ch*chmul+i
  function automatic logic [127:0] blk4(input int ch, input int b, input int chmul);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*16 +: 16] = 16'(ch * chmul + b * 4 + k);
    return r;
  endfunction

  task automatic a_write(input int idx, input int val, input bit last);
    a_wr_valid = 1'b1;
    a_wr_index = 13'(idx);
    a_wr_data  = 16'(val);
    a_wr_last  = last;
    tick();
    a_wr_valid = 1'b0;
    a_wr_last  = 1'b0;
  endtask

  task automatic a_read(input int blk);
    a_rd_valid = 1'b1;
    a_rd_block = 10'(blk);
    tick();
    a_rd_valid = 1'b0;
  endtask

  task automatic a_start();
    a_load_start = 1'b1;
    tick();
    a_load_start = 1'b0;
  endtask

  task automatic pulse_trigger();
    audio_trigger = 1'b1;
    tick();
    audio_trigger = 1'b0;
  endtask

  task automatic b_write(input int ch, input int idx, input int val, input bit last);
    b_wr_valid = 1'b1;
    b_wr_ch    = 2'(ch);
    b_wr_index = 6'(idx);
    b_wr_data  = 16'(val);
    b_wr_last  = last;
    tick();
    b_wr_valid = 1'b0;
    b_wr_last  = 1'b0;
  endtask

  task automatic c_write(input int ch, input int idx, input int val, input bit last);
    c_wr_valid = 1'b1;
    c_wr_ch    = 2'(ch);
    c_wr_index = 4'(idx);
    c_wr_data  = 16'(val);
    c_wr_last  = last;
    tick();
    c_wr_valid = 1'b0;
    c_wr_last  = 1'b0;
  endtask

  task automatic c_read(input int ch, input int blk);
    c_rd_valid = 1'b1;
    c_rd_ch    = 2'(ch);
    c_rd_block = 2'(blk);
    tick();
    c_rd_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b0; audio_trigger = 1'b0;
    a_load_start = 0; a_wr_valid = 0; a_wr_ch = '0; a_wr_index = '0; a_wr_data = '0;
    a_wr_last = 0; a_rd_valid = 0; a_rd_ch = '0; a_rd_block = '0;
    b_load_start = 0; b_wr_valid = 0; b_wr_ch = '0; b_wr_index = '0; b_wr_data = '0;
    b_wr_last = 0; b_rd_valid = 0; b_rd_ch = '0; b_rd_block = '0;
    c_load_start = 0; c_wr_valid = 0; c_wr_ch = '0; c_wr_index = '0; c_wr_data = '0;
    c_wr_last = 0; c_rd_valid = 0; c_rd_ch = '0; c_rd_block = '0;

    // Test-1 read vectors on page holding tap i = +i
    tv[0] = '{1'b1, 10'd3,    1'b1, 128'h001f_001e_001d_001c_001b_001a_0019_0018};
    tv[1] = '{1'b1, 10'd0,    1'b1, 128'h0007_0006_0005_0004_0003_0002_0001_0000};
    tv[2] = '{1'b1, 10'd749,  1'b1, a_blk(749, 1, 0)};
    tv[3] = '{1'b1, 10'd750,  1'b1, 128'h0};
    tv[4] = '{1'b1, 10'd1023, 1'b1, 128'h0};
    tv[5] = '{1'b1, 10'd5,    1'b1, a_blk(5, 1, 0)};
    tv[6] = '{1'b0, 10'd3,    1'b0, a_blk(5, 1, 0)};
    tv[7] = '{1'b1, 10'd3,    1'b1, 128'h001f_001e_001d_001c_001b_001a_0019_0018};

    tick(); tick();
    check("rst_active_page", a_active_page, 0);
    check("rst_ir_ready", a_ir_ready, 0);
    check("rst_wr_ready", a_wr_ready, 0);
    check("rst_wr_err", a_wr_err, 0);
    check("rst_rd_valid", a_rd_data_valid, 0);
    check("rst_rd_data", a_rd_data, 0);
    rst_in = 1'b1;
    tick();

    // Test 1: full load of +i, swap, table-driven reads
    a_start();
    check("t1_wr_ready", a_wr_ready, 1);
    for (int i = 0; i < 6000; i++) a_write(i, i, i == 5999);
    check("t1_pending_wr_ready", a_wr_ready, 0);
    tick();
    check("t1_no_swap_yet", a_active_page, 0);
    pulse_trigger();
    check("t1_active_page", a_active_page, 1);
    check("t1_ir_ready", a_ir_ready, 1);
    for (int i = 0; i < 8; i++) begin
      a_rd_valid = tv[i].v;
      a_rd_block = tv[i].blk;
      tick();
      check($sformatf("t1_vec%0d_valid", i), a_rd_data_valid, tv[i].ev);
      check($sformatf("t1_vec%0d_data", i), a_rd_data, tv[i].ed);
    end
    a_rd_valid = 1'b0;

    // Test 2: load -i while reading the old page; swap-cycle read sees the old page
    a_start();
    for (int i = 0; i < 6000; i++) begin
      a_rd_valid = 1'b1;
      a_rd_block = 10'(i % 750);
      a_write(i, -i, i == 5999);
      if (i % 500 == 0) check("t2_old_page_during_load", a_rd_data, a_blk(i % 750, 1, 0));
    end
    for (int j = 0; j < 3; j++) begin
      a_rd_block = 10'(j + 10);
      tick();
      check("t2_old_page_pending", a_rd_data, a_blk(j + 10, 1, 0));
      check("t2_page_held", a_active_page, 1);
    end
    a_rd_block = 10'd3;
    audio_trigger = 1'b1;
    tick();
    audio_trigger = 1'b0;
    check("t2_swap_cycle_read", a_rd_data, a_blk(3, 1, 0));
    check("t2_active_page", a_active_page, 0);
    tick();
    check("t2_new_page_read", a_rd_data, a_blk(3, -1, 0));
    a_rd_valid = 1'b0;

    // Tests 3 and 4: out-of-range writes, then wr_last coincident with a trigger
    a_start();
    a_write(6000, 16'h7777, 1'b0);
    check("t4_err_index_6000", a_wr_err, 1);
    a_write(8191, 16'h7777, 1'b0);
    check("t4_err_index_8191", a_wr_err, 1);
    for (int i = 0; i < 7; i++) begin
      a_write(i, 100 + i, 1'b0);
      if (i == 0) check("t4_err_cleared", a_wr_err, 0);
    end
    audio_trigger = 1'b1;
    a_write(7, 107, 1'b1);
    audio_trigger = 1'b0;
    check("t3_no_swap_same_cycle", a_active_page, 0);
    check("t3_pending_wr_ready", a_wr_ready, 0);
    tick();
    check("t3_no_swap_idle_cycle", a_active_page, 0);
    pulse_trigger();
    check("t3_swap_next_trigger", a_active_page, 1);
    a_read(0);
    check("t3_block0", a_rd_data, a_blk(0, 1, 100));
    a_read(3);
    check("t4_block3_unchanged", a_rd_data, a_blk(3, 1, 0));
    a_read(749);
    check("t4_block749_unchanged", a_rd_data, a_blk(749, 1, 0));
    a_read(750);
    check("t4_block750_data", a_rd_data, 0);
    check("t4_block750_valid", a_rd_data_valid, 1);

    // Test 5: asynchronous reset mid-load, then a fresh load
    a_start();
    a_rd_valid = 1'b1;
    a_rd_block = 10'd3;
    for (int i = 0; i < 100; i++) a_write(i, 9000 + i, 1'b0);
    check("t5_pre_rd_valid", a_rd_data_valid, 1);
    a_wr_valid = 1'b1;
    a_wr_index = 13'd100;
    #2 rst_in = 1'b0;
    #1;
    check("t5_rst_active_page", a_active_page, 0);
    check("t5_rst_ir_ready", a_ir_ready, 0);
    check("t5_rst_wr_ready", a_wr_ready, 0);
    check("t5_rst_wr_err", a_wr_err, 0);
    check("t5_rst_rd_valid", a_rd_data_valid, 0);
    check("t5_rst_rd_data", a_rd_data, 0);
    a_wr_valid = 1'b0;
    a_rd_valid = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    check("t5_idle_after_reset", a_wr_ready, 0);
    a_start();
    for (int i = 0; i < 6000; i++) a_write(i, 3 * i, i == 5999);
    pulse_trigger();
    check("t5_active_page", a_active_page, 1);
    check("t5_ir_ready", a_ir_ready, 1);
    a_read(0);
    check("t5_block0", a_rd_data, a_blk(0, 3, 0));
    a_read(749);
    check("t5_block749", a_rd_data, a_blk(749, 3, 0));

    // Test 6: four channels interleaved, every block read back
    b_load_start = 1'b1;
    tick();
    b_load_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      for (int c = 0; c < 4; c++) b_write(c, i, c * 1000 + i, (i == 63) && (c == 3));
    end
    pulse_trigger();
    check("t6_active_page", b_active_page, 1);
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < 16; b++) begin
        b_rd_valid = 1'b1;
        b_rd_ch    = 2'(c);
        b_rd_block = 4'(b);
        tick();
        check($sformatf("t6_ch%0d_blk%0d", c, b), b_rd_data, blk4(c, b, 1000));
      end
    end
    b_rd_valid = 1'b0;

    // Out-of-range channel on a three-channel instance
    c_load_start = 1'b1;
    tick();
    c_load_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 16; i++) c_write(c, i, c * 100 + i, 1'b0);
    end
    c_write(3, 0, 16'h7777, 1'b0);
    check("c_err_channel3", c_wr_err, 1);
    c_write(0, 0, 0, 1'b1);
    check("c_err_cleared", c_wr_err, 0);
    pulse_trigger();
    check("c_active_page", c_active_page, 1);
    c_read(3, 0);
    check("c_ch3_data", c_rd_data, 0);
    check("c_ch3_valid", c_rd_data_valid, 1);
    c_read(2, 3);
    check("c_ch2_blk3", c_rd_data, blk4(2, 3, 100));
    c_read(0, 0);
    check("c_ch0_blk0", c_rd_data, blk4(0, 0, 100));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
